// File: rtl/light_display_pkg.sv
`default_nettype none
// ============================================================================
// Module      : light_display_pkg
// Description : Types and constants shared by the instruction parser and the
//               downstream light display stage.
// Revision    : 1.0 - initial release
// ============================================================================
package light_display_pkg;

    localparam int C_POSITION_BITS     = 12;
    localparam int C_INSTRUCTION_WIDTH = 2 + 4 * C_POSITION_BITS;

    // Operation field of a command word; 2'b10 is never produced.
    typedef enum logic [1:0] {
        OP_TURN_OFF = 2'b00,
        OP_TOGGLE   = 2'b01,
        OP_TURN_ON  = 2'b11
    } op_e;

    // Packed command word, MSB first.
    typedef struct packed {
        op_e                        op;
        logic [C_POSITION_BITS-1:0] start_row;
        logic [C_POSITION_BITS-1:0] start_col;
        logic [C_POSITION_BITS-1:0] end_row;
        logic [C_POSITION_BITS-1:0] end_col;
    } cmd_s;

    function automatic logic is_digit(input logic [7:0] c);
        return (c >= 8'h30) && (c <= 8'h39);
    endfunction

    function automatic logic is_letter(input logic [7:0] c);
        return ((c >= 8'h61) && (c <= 8'h7A)) || ((c >= 8'h41) && (c <= 8'h5A));
    endfunction

endpackage : light_display_pkg
`default_nettype wire

// File: rtl/decimal_accumulator.sv
`default_nettype none
// ============================================================================
// Module      : decimal_accumulator
// Description : Builds a decimal number one digit at a time, modulo 2^WIDTH.
//               o_acc_next exposes the value the next digit would produce so a
//               number ending on the final byte can be captured directly.
// Revision    : 1.0 - initial release
// ============================================================================
module decimal_accumulator #(
    parameter int WIDTH = 12
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             i_clear,
    input  logic             i_digit_valid,
    input  logic [3:0]       i_digit,
    output logic [WIDTH-1:0] o_acc,
    output logic [WIDTH-1:0] o_acc_next
);

    logic [WIDTH-1:0] r_acc;

    // acc*10 + digit, with x10 formed from two shifts; wraps naturally.
    always_comb begin
        o_acc_next = (r_acc << 3) + (r_acc << 1) + {{(WIDTH-4){1'b0}}, i_digit};
    end

    // Accumulator register; clear wins over a digit in the same cycle.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_acc <= '0;
        end else if (i_clear) begin
            r_acc <= '0;
        end else if (i_digit_valid) begin
            r_acc <= o_acc_next;
        end
    end

    assign o_acc = r_acc;

endmodule : decimal_accumulator
`default_nettype wire

// File: rtl/instruction_parser.sv
`default_nettype none
// ============================================================================
// Module      : instruction_parser
// Description : Decodes the ASCII puzzle text into packed command words for
//               the light display stage. A one-deep lookahead buffer lets the
//               final command be tagged with instr_last even when the input
//               ends in blank or malformed lines.
// Revision    : 1.0 - initial release
// ============================================================================
module instruction_parser
    import light_display_pkg::*;
#(
    parameter int INSTRUCTION_WIDTH = C_INSTRUCTION_WIDTH,
    parameter int POSITION_BITS     = C_POSITION_BITS
) (
    input  logic                         clk,
    input  logic                         reset_n,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic [7:0]                   in_data,
    input  logic                         in_last,
    output logic                         instr_valid,
    input  logic                         instr_ready,
    output logic [INSTRUCTION_WIDTH-1:0] instr_data,
    output logic                         instr_last,
    output logic                         parse_done
);

    typedef enum logic [1:0] {
        ST_PARSE     = 2'd0,
        ST_FLUSH     = 2'd1,
        ST_WAIT_LAST = 2'd2,
        ST_DONE      = 2'd3
    } state_e;

    localparam logic [7:0] c_char_lf    = 8'h0A;
    localparam logic [7:0] c_char_o     = 8'h6F;
    localparam logic [7:0] c_char_n     = 8'h6E;
    localparam logic [7:0] c_char_f     = 8'h66;
    localparam logic [2:0] c_field_sat  = 3'd5;
    localparam logic [2:0] c_letter_sat = 3'd7;

    // Control / output registers
    state_e                       r_state;
    state_e                       w_state_next;
    logic                         r_in_ready;
    logic                         w_in_ready_next;
    logic                         r_out_valid;
    logic                         w_out_valid_next;
    logic [INSTRUCTION_WIDTH-1:0] r_out_data;
    logic [INSTRUCTION_WIDTH-1:0] w_out_data_next;
    logic                         r_out_last;
    logic                         w_out_last_next;
    logic [INSTRUCTION_WIDTH-1:0] r_pend_data;
    logic [INSTRUCTION_WIDTH-1:0] w_pend_data_next;
    logic                         r_pend_full;
    logic                         w_pend_full_next;

    // Per-line decode state
    logic [2:0]               r_field_cnt;
    logic [2:0]               r_letter_idx;
    logic                     r_in_num;
    logic                     r_toggle;
    op_e                      r_op_sel;
    logic [POSITION_BITS-1:0] r_field [4];

    // Byte classification
    logic                         w_byte_fire;
    logic                         w_is_digit;
    logic                         w_is_letter;
    logic                         w_line_end;
    logic                         w_run_close;
    logic                         w_run_at_end;
    logic [2:0]                   w_end_cnt;
    logic                         w_yield;
    logic [POSITION_BITS-1:0]     w_acc;
    logic [POSITION_BITS-1:0]     w_acc_next;
    logic [POSITION_BITS-1:0]     w_run_val;
    logic [POSITION_BITS-1:0]     w_end_col;
    op_e                          w_op;
    logic [INSTRUCTION_WIDTH-1:0] w_new_cmd;

    decimal_accumulator #(
        .WIDTH (POSITION_BITS)
    ) u_acc (
        .clk           (clk),
        .reset_n       (reset_n),
        .i_clear       (w_line_end || (w_byte_fire && !w_is_digit)),
        .i_digit_valid (w_byte_fire && w_is_digit),
        .i_digit       (in_data[3:0]),
        .o_acc         (w_acc),
        .o_acc_next    (w_acc_next)
    );

    // Classify the accepted byte and assemble the command a line end would yield.
    always_comb begin
        w_byte_fire  = in_valid && r_in_ready;
        w_is_digit   = is_digit(in_data);
        w_is_letter  = is_letter(in_data);
        w_line_end   = w_byte_fire && ((in_data == c_char_lf) || in_last);
        w_run_close  = w_byte_fire && r_in_num && !w_is_digit;
        // A digit on the terminating byte still belongs to the last field.
        w_run_at_end = r_in_num || w_is_digit;
        w_end_cnt    = r_field_cnt + (w_run_at_end ? 3'd1 : 3'd0);
        w_yield      = w_line_end && (w_end_cnt == 3'd4);
        w_run_val    = w_is_digit ? w_acc_next : w_acc;
        w_end_col    = (r_field_cnt == 3'd3) ? w_run_val : r_field[3];
        w_op         = r_toggle ? OP_TOGGLE : r_op_sel;
        w_new_cmd    = {w_op, r_field[0], r_field[1], r_field[2], w_end_col};
    end

    // Per-line decode: field capture, letter counting and op selection.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_field_cnt  <= 3'd0;
            r_letter_idx <= 3'd0;
            r_in_num     <= 1'b0;
            r_toggle     <= 1'b0;
            r_op_sel     <= OP_TURN_ON;
            for (int i = 0; i < 4; i++) begin
                r_field[i] <= '0;
            end
        end else if (w_line_end) begin
            r_field_cnt  <= 3'd0;
            r_letter_idx <= 3'd0;
            r_in_num     <= 1'b0;
            r_toggle     <= 1'b0;
            r_op_sel     <= OP_TURN_ON;
        end else if (w_byte_fire) begin
            r_in_num <= w_is_digit;
            if (w_run_close) begin
                if (r_field_cnt < 3'd4) begin
                    r_field[r_field_cnt[1:0]] <= w_acc;
                end
                if (r_field_cnt != c_field_sat) begin
                    r_field_cnt <= r_field_cnt + 3'd1;
                end
            end
            if (w_is_letter) begin
                if ((r_letter_idx == 3'd1) && (in_data == c_char_o)) begin
                    r_toggle <= 1'b1;
                end
                if (r_letter_idx == 3'd6) begin
                    if (in_data == c_char_n) begin
                        r_op_sel <= OP_TURN_ON;
                    end else if (in_data == c_char_f) begin
                        r_op_sel <= OP_TURN_OFF;
                    end
                end
                if (r_letter_idx != c_letter_sat) begin
                    r_letter_idx <= r_letter_idx + 3'd1;
                end
            end
        end
    end

    // Next-state, lookahead buffer and output register updates.
    always_comb begin
        w_state_next     = r_state;
        w_out_valid_next = r_out_valid && !instr_ready;
        w_out_data_next  = r_out_data;
        w_out_last_next  = r_out_last;
        w_pend_data_next = r_pend_data;
        w_pend_full_next = r_pend_full;
        case (r_state)
            ST_PARSE: begin
                if (w_yield) begin
                    w_pend_data_next = w_new_cmd;
                    w_pend_full_next = 1'b1;
                    if (r_pend_full) begin
                        w_out_data_next  = r_pend_data;
                        w_out_valid_next = 1'b1;
                        w_out_last_next  = 1'b0;
                    end
                end
                if (w_byte_fire && in_last) begin
                    w_state_next = ST_FLUSH;
                end
            end
            ST_FLUSH: begin
                if (!r_out_valid) begin
                    if (r_pend_full) begin
                        w_out_data_next  = r_pend_data;
                        w_out_valid_next = 1'b1;
                        w_out_last_next  = 1'b1;
                        w_pend_full_next = 1'b0;
                        w_state_next     = ST_WAIT_LAST;
                    end else begin
                        w_state_next = ST_DONE;
                    end
                end
            end
            ST_WAIT_LAST: begin
                if (r_out_valid && instr_ready) begin
                    w_state_next = ST_DONE;
                end
            end
            default: begin
                w_state_next = ST_DONE;
            end
        endcase
        w_in_ready_next = (w_state_next == ST_PARSE) && !w_out_valid_next;
    end

    // State and datapath registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state     <= ST_PARSE;
            r_in_ready  <= 1'b0;
            r_out_valid <= 1'b0;
            r_out_data  <= '0;
            r_out_last  <= 1'b0;
            r_pend_data <= '0;
            r_pend_full <= 1'b0;
        end else begin
            r_state     <= w_state_next;
            r_in_ready  <= w_in_ready_next;
            r_out_valid <= w_out_valid_next;
            r_out_data  <= w_out_data_next;
            r_out_last  <= w_out_last_next;
            r_pend_data <= w_pend_data_next;
            r_pend_full <= w_pend_full_next;
        end
    end

    assign in_ready    = r_in_ready;
    assign instr_valid = r_out_valid;
    assign instr_data  = r_out_data;
    assign instr_last  = r_out_last;
    assign parse_done  = (r_state == ST_DONE);

endmodule : instruction_parser
`default_nettype wire

// File: tb/tb_instruction_parser.sv
`default_nettype none
// ============================================================================
// Module      : tb_instruction_parser
// Description : Self-checking bench for instruction_parser: directed puzzle
//               lines plus random text streams scored against a line-level
//               reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_instruction_parser;

    logic        clk         = 1'b0;
    logic        reset_n     = 1'b0;
    logic        in_valid    = 1'b0;
    logic [7:0]  in_data     = 8'h00;
    logic        in_last     = 1'b0;
    logic        instr_ready = 1'b0;
    logic        in_ready;
    logic        instr_valid;
    logic [49:0] instr_data;
    logic        instr_last;
    logic        parse_done;

    int n_total = 0;
    int n_pass  = 0;
    int n_fail  = 0;

    byte unsigned stream[$];
    logic [49:0]  exp_data[$];
    logic         exp_last[$];

    instruction_parser #(
        .INSTRUCTION_WIDTH (50),
        .POSITION_BITS     (12)
    ) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_data     (in_data),
        .in_last     (in_last),
        .instr_valid (instr_valid),
        .instr_ready (instr_ready),
        .instr_data  (instr_data),
        .instr_last  (instr_last),
        .parse_done  (parse_done)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic push_str(input string s);
        for (int i = 0; i < s.len(); i++) stream.push_back(s[i]);
    endtask

    task automatic add_exp(input int op, input int a, input int b, input int c, input int d,
                           input logic last);
        exp_data.push_back({2'(op), 12'(a), 12'(b), 12'(c), 12'(d)});
        exp_last.push_back(last);
    endtask

    function automatic bit tb_letter(input byte unsigned c);
        return (c >= 8'd97 && c <= 8'd122) || (c >= 8'd65 && c <= 8'd90);
    endfunction

    // Line-level reference: collect numbers per line, emit lines with four.
    task automatic model_stream();
        int nums[$];
        int letters;
        int op6;
        bit tog;
        bit run;
        int val;
        int n;
        byte unsigned c;
        bit is_end;
        letters = 0; op6 = 3; tog = 0; run = 0; val = 0;
        n = stream.size();
        exp_data.delete();
        exp_last.delete();
        for (int i = 0; i < n; i++) begin
            c = stream[i];
            is_end = (c == 8'h0A) || (i == n - 1);
            if (c >= 8'd48 && c <= 8'd57) begin
                val = (val * 10 + int'(c) - 48) % 4096;
                run = 1;
            end else begin
                if (run) begin
                    nums.push_back(val);
                    val = 0;
                    run = 0;
                end
                if (tb_letter(c) && !is_end) begin
                    if (letters == 1 && c == 8'h6F) tog = 1;
                    if (letters == 6 && c == 8'h6E) op6 = 3;
                    if (letters == 6 && c == 8'h66) op6 = 0;
                    letters++;
                end
            end
            if (is_end) begin
                if (run) nums.push_back(val);
                if (nums.size() == 4) add_exp(tog ? 1 : op6, nums[0], nums[1], nums[2], nums[3], 1'b0);
                nums.delete();
                letters = 0; op6 = 3; tog = 0; run = 0; val = 0;
            end
        end
        if (exp_last.size() > 0) exp_last[exp_last.size() - 1] = 1'b1;
    endtask

    task automatic do_reset();
        in_valid    = 1'b0;
        in_last     = 1'b0;
        in_data     = 8'h00;
        instr_ready = 1'b0;
        #2 reset_n = 1'b0;
        #1;
        check("rst_in_ready", in_ready, 0);
        check("rst_instr_valid", instr_valid, 0);
        check("rst_instr_data", instr_data, 0);
        check("rst_instr_last", instr_last, 0);
        check("rst_parse_done", parse_done, 0);
        @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        check("in_ready_after_reset", in_ready, 1);
    endtask

    // Drive the stream and score every delivered command.
    // mode 0: always ready/valid, 1: random, 2: stall downstream 20 cycles.
    task automatic run_stream(input int mode);
        int idx;
        int got;
        int cyc;
        int hold;
        int n_exp;
        bit have_prev;
        logic [49:0] prev_d;
        logic prev_l;
        idx = 0; got = 0; cyc = 0; hold = 0; have_prev = 0; prev_d = '0; prev_l = 0;
        n_exp = exp_data.size();
        while (!(parse_done === 1'b1 && idx == stream.size()) && cyc < 4000) begin
            @(negedge clk);
            cyc++;
            if (have_prev) begin
                check("hold_valid", instr_valid, 1);
                check("hold_data", instr_data, prev_d);
                check("hold_last", instr_last, prev_l);
            end
            check("ready_while_valid", in_ready && instr_valid, 0);
            if (idx < stream.size()) begin
                in_valid = (mode == 1) ? ($urandom_range(0, 3) != 0) : 1'b1;
                in_data  = stream[idx];
                in_last  = (idx == stream.size() - 1);
            end else begin
                in_valid = 1'b0;
                in_last  = 1'b0;
            end
            case (mode)
                0:       instr_ready = 1'b1;
                1:       instr_ready = ($urandom_range(0, 2) != 0);
                default: instr_ready = (hold >= 20);
            endcase
            if (in_valid && in_ready) idx++;
            have_prev = 0;
            if (instr_valid === 1'b1) begin
                if (!instr_ready) hold++;
                if (instr_ready) begin
                    got++;
                    if (exp_data.size() == 0) begin
                        check("unexpected_cmd", instr_data, 0);
                    end else begin
                        check("cmd_data", instr_data, exp_data[0]);
                        check("cmd_last", instr_last, exp_last[0]);
                        void'(exp_data.pop_front());
                        void'(exp_last.pop_front());
                    end
                end else begin
                    have_prev = 1;
                    prev_d = instr_data;
                    prev_l = instr_last;
                end
            end
        end
        in_valid = 1'b0;
        in_last  = 1'b0;
        check("no_timeout", cyc < 4000, 1);
        check("cmd_count", got, n_exp);
        @(negedge clk);
        check("parse_done", parse_done, 1);
        check("idle_valid", instr_valid, 0);
        check("idle_in_ready", in_ready, 0);
    endtask

    task automatic feed_no_last(input int max_cycles);
        int idx;
        idx = 0;
        for (int c = 0; c < max_cycles && idx < stream.size(); c++) begin
            @(negedge clk);
            in_valid    = 1'b1;
            in_data     = stream[idx];
            in_last     = 1'b0;
            instr_ready = 1'b0;
            if (in_ready) idx++;
        end
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    function automatic int rnum();
        return ($urandom_range(0, 9) == 0) ? int'($urandom_range(0, 99999)) : int'($urandom_range(0, 999));
    endfunction

    task automatic gen_random(input int nlines);
        string eol;
        string ops;
        int k;
        stream.delete();
        for (int l = 0; l < nlines; l++) begin
            k   = $urandom_range(0, 7);
            eol = ($urandom_range(0, 3) == 0) ? "\r\n" : "\n";
            case ($urandom_range(0, 2))
                0:       ops = "turn on";
                1:       ops = "turn off";
                default: ops = "toggle";
            endcase
            case (k)
                3: push_str(eol);
                4: push_str($sformatf("%s %0d,%0d through %0d%s", ops, rnum(), rnum(), rnum(), eol));
                5: push_str($sformatf("%s %0d,%0d through %0d,%0d,%0d%s", ops, rnum(), rnum(), rnum(), rnum(), rnum(), eol));
                6: push_str($sformatf("%s %0d%s", ops, rnum(), eol));
                default: push_str($sformatf("%s %0d,%0d through %0d,%0d%s", ops, rnum(), rnum(), rnum(), rnum(), eol));
            endcase
        end
        if ($urandom_range(0, 1) == 1 && stream.size() > 2) begin
            void'(stream.pop_back());
            if (stream[stream.size() - 1] == 8'h0D) void'(stream.pop_back());
            if (stream.size() == 0) push_str("\n");
        end
    endtask

    initial begin
        // Single toggle line followed by a blank final line.
        do_reset();
        stream.delete();
        push_str("toggle 461,550 through 564,900\n\n");
        exp_data.delete(); exp_last.delete();
        add_exp(1, 461, 550, 564, 900, 1'b1);
        run_stream(0);

        // Two lines, last flag on the second command.
        do_reset();
        stream.delete();
        push_str("turn on 0,0 through 999,999\nturn off 499,499 through 500,500\n");
        exp_data.delete(); exp_last.delete();
        add_exp(3, 0, 0, 999, 999, 1'b0);
        add_exp(0, 499, 499, 500, 500, 1'b1);
        run_stream(0);

        // Same two lines with downstream stalled for 20 cycles.
        do_reset();
        exp_data.delete(); exp_last.delete();
        add_exp(3, 0, 0, 999, 999, 1'b0);
        add_exp(0, 499, 499, 500, 500, 1'b1);
        run_stream(2);

        // Final line without newline, in_last on the last digit.
        do_reset();
        stream.delete();
        push_str("toggle 1,2 through 3,4");
        exp_data.delete(); exp_last.delete();
        add_exp(1, 1, 2, 3, 4, 1'b1);
        run_stream(1);

        // Only blank and malformed lines: nothing emitted.
        do_reset();
        stream.delete();
        push_str("\n\r\nturn on 5,5 through 6\n");
        exp_data.delete(); exp_last.delete();
        run_stream(0);

        // Reset while a command is being offered downstream.
        do_reset();
        stream.delete();
        push_str("turn on 1,1 through 2,2\nturn on 3,3 through 4,4\n");
        feed_no_last(80);
        check("valid_before_reset", instr_valid, 1);

        // Reset mid-line, then a clean line must parse with no leftovers.
        do_reset();
        stream.delete();
        push_str("turn on 12,3");
        feed_no_last(40);
        do_reset();
        stream.delete();
        push_str("turn on 7,7 through 8,8\n");
        exp_data.delete(); exp_last.delete();
        add_exp(3, 7, 7, 8, 8, 1'b1);
        run_stream(1);

        // Random streams against the line-level model.
        for (int t = 0; t < 12; t++) begin
            do_reset();
            gen_random($urandom_range(1, 8));
            model_stream();
            run_stream(t % 2);
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule : tb_instruction_parser
`default_nettype wire
